timeout: RTL and testbench

// Programmable down-counting timeout timer. A load strobe arms the timer with a

---
 rtl/timeout_if.sv | 21 ++
 rtl/timeout.sv | 59 +++++
 tb/tb_timeout.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/timeout_if.sv
// Load/arm bus of the timeout timer.
// Master arms with count/put and observes full.
interface timeout_if #(
  parameter int W = 8
);
  logic [W-1:0] count;
  logic         put;
  logic         full;

  modport master (
    output count,
    output put,
    input  full
  );

  modport slave (
    input  count,
    input  put,
    output full
  );
endinterface

// File: rtl/timeout.sv
// Programmable down-counting timeout timer.
// full is a decoded state flop, so it has no path from inputs.
module timeout #(
  parameter int W = 8
) (
  input  logic     clock,
  input  logic     reset,
  timeout_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_cnt;
  logic [W-1:0]   w_cnt_nxt;
  logic           w_load;
  logic           w_dec;

  assign w_load = bus.put;
  assign w_dec  = !bus.put && (r_cnt != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Reload wins over decrement; count 0 never leaves idle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (1'b1)
      w_load: begin
        w_cnt_nxt   = bus.count;
        w_state_nxt = (bus.count == '0)
                    ? S_IDLE : S_RUN;
      end
      w_dec: begin
        w_cnt_nxt   = r_cnt - W'(1);
        w_state_nxt = (r_cnt == W'(1))
                    ? S_IDLE : S_RUN;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.full = (r_state == S_IDLE);

endmodule

// File: tb/tb_timeout.sv
// Directed bench for the timeout timer.
// Inputs driven and full sampled on the falling edge.
module tb_timeout;

  localparam int W = 8;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  timeout_if #(.W(W)) u_if ();

  timeout #(.W(W)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic exp);
    n_cmp++;
    assert (u_if.full === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b t=%0t",
             tag, u_if.full, exp, $time);
    end
  endtask

  // single-cycle put; returns just after the load edge
  task automatic arm(input logic [W-1:0] n);
    @(negedge clock);
    u_if.count = n;
    u_if.put   = 1'b1;
    @(negedge clock);
    u_if.put   = 1'b0;
    u_if.count = 8'hA5;
  endtask

  // called right after load edge E: low through E+n-1, high after E+n
  task automatic expect_run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check(tag, 1'b0);
      @(negedge clock);
    end
    check(tag, 1'b1);
  endtask

  task automatic expect_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check(tag, 1'b1);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b0;
    u_if.put   = 1'b0;
    u_if.count = '0;

    // 1: reset, then idle with no put
    repeat (2) @(negedge clock);
    check("rst_hold", 1'b1);
    reset = 1'b1;
    expect_idle(5, "rst_idle");

    // 2: count 10, single put
    arm(8'd10);
    expect_run(10, "cnt10");
    expect_idle(5, "cnt10_hold");

    // 3: arm 30, reload 20 at the 12th cycle
    arm(8'd30);
    repeat (11) begin
      check("rearm_pre", 1'b0);
      @(negedge clock);
    end
    check("rearm_pre", 1'b0);
    arm(8'd20);
    expect_run(20, "rearm20");
    expect_idle(3, "rearm_hold");

    // 4: put held 4 cycles with count 20
    @(negedge clock);
    u_if.count = 8'd20;
    u_if.put   = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("held_put", 1'b0);
    end
    u_if.put = 1'b0;
    @(negedge clock);
    expect_run(19, "held20");

    // count changing while put held: last value wins
    @(negedge clock);
    u_if.count = 8'd3;
    u_if.put   = 1'b1;
    @(negedge clock);
    u_if.count = 8'd7;
    @(negedge clock);
    u_if.put   = 1'b0;
    expect_run(7, "chg7");

    // 5: zero count expires at once
    arm(8'd0);
    check("zero_idle", 1'b1);
    arm(8'd5);
    check("zero_arm5", 1'b0);
    arm(8'd0);
    check("zero_abort", 1'b1);
    expect_idle(4, "zero_hold");

    // count 1: single low cycle
    arm(8'd1);
    expect_run(1, "one");

    // maximum count
    arm(8'd255);
    expect_run(255, "max255");
    expect_idle(3, "max_hold");

    // 6: reset aborts a running count asynchronously
    arm(8'd11);
    repeat (5) @(negedge clock);
    check("rst_pre", 1'b0);
    #2 reset = 1'b0;
    #1 check("rst_async", 1'b1);
    repeat (2) @(negedge clock);
    check("rst_low", 1'b1);
    reset = 1'b1;
    expect_idle(15, "rst_after");

    // recovers normally after reset
    arm(8'd4);
    expect_run(4, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
